// File: rtl/index_decode_accum_pkg.sv
// Shared types and helpers for the index decode accumulator.
// Holds the FSM state encoding and a width-generic popcount.
package index_decode_accum_pkg;

  localparam int MaxWidth = 256;

  typedef enum logic {
    COLLECT = 1'b0,
    EMIT    = 1'b1
  } stateT;

  // Callers zero-extend their vector to MaxWidth before counting.
  function automatic int popCount(input logic [MaxWidth-1:0] vec);
    int total;
    total = 0;
    for (int i = 0; i < MaxWidth; i++) begin
      total += int'(vec[i]);
    end
    return total;
  endfunction

endpackage

// File: rtl/index_decode_accum_decoder.sv
// Binary index to one-hot decoder used to select the mask bit to write.
module nBitDecoder #(
  parameter int N = 8,
  parameter int W = 3
) (
  input  logic [W-1:0] index,
  output logic [N-1:0] oneHot
);

  assign oneHot = N'(1) << index;

endmodule

// File: rtl/index_decode_accum.sv
// Collects indexed bit writes into a mask and emits it on Flush or when full.
// Emitted mask is held until the consumer accepts it, then cleared.
module index_decode_accum
  import index_decode_accum_pkg::*;
#(
  parameter int N = 8,
  localparam int W = $clog2(N)
) (
  input  logic         Clock,
  input  logic         ResetN,
  input  logic         InValid,
  output logic         InReady,
  input  logic [W-1:0] InIndex,
  input  logic         InSet,
  input  logic         Flush,
  output logic         OutValid,
  input  logic         OutReady,
  output logic [N-1:0] OutMask,
  output logic [W:0]   OutCount
);

  if ((N < 4) || ((N & (N - 1)) != 0) || (N > MaxWidth)) begin : gBadParam
    $fatal(1, "index_decode_accum: N must be a power of 2, at least 4 and at most MaxWidth");
  end

  stateT        state;
  stateT        nextState;
  logic [N-1:0] maskReg;
  logic [N-1:0] maskNext;
  logic [N-1:0] oneHot;
  logic         inXfer;

  nBitDecoder #(
    .N(N),
    .W(W)
  ) decoder (
    .index  (InIndex),
    .oneHot (oneHot)
  );

  assign InReady  = (state == COLLECT);
  assign OutValid = (state == EMIT);
  assign OutMask  = maskReg;
  assign OutCount = (W+1)'(popCount(MaxWidth'(maskReg)));
  assign inXfer   = InValid && InReady;

  // The write is applied before the emit decision so a same-cycle index joins the group.
  always_comb begin
    nextState = state;
    maskNext  = maskReg;
    case (state)
      COLLECT: begin
        if (inXfer) begin
          maskNext = InSet ? (maskReg | oneHot) : (maskReg & ~oneHot);
        end
        if (Flush || (&maskNext)) begin
          nextState = EMIT;
        end
      end
      EMIT: begin
        if (OutReady) begin
          maskNext  = '0;
          nextState = COLLECT;
        end
      end
      default: begin
        nextState = COLLECT;
        maskNext  = '0;
      end
    endcase
  end

  always_ff @(posedge Clock or negedge ResetN) begin
    if (!ResetN) begin
      state   <= COLLECT;
      maskReg <= '0;
    end else begin
      state   <= nextState;
      maskReg <= maskNext;
    end
  end

endmodule

// File: tb/tb_index_decode_accum.sv
// Self-checking bench for index_decode_accum: directed scenarios plus a
// randomized run scored against a bit-array model of the accumulator.
module tb_index_decode_accum;

  localparam int N = 8;
  localparam int W = 3;

  logic         Clock;
  logic         ResetN;
  logic         InValid;
  logic         InReady;
  logic [W-1:0] InIndex;
  logic         InSet;
  logic         Flush;
  logic         OutValid;
  logic         OutReady;
  logic [N-1:0] OutMask;
  logic [W:0]   OutCount;

  int checks;
  int errors;

  bit modelBits [N];
  bit modelEmit;

  index_decode_accum #(.N(N)) dut (
    .Clock    (Clock),
    .ResetN   (ResetN),
    .InValid  (InValid),
    .InReady  (InReady),
    .InIndex  (InIndex),
    .InSet    (InSet),
    .Flush    (Flush),
    .OutValid (OutValid),
    .OutReady (OutReady),
    .OutMask  (OutMask),
    .OutCount (OutCount)
  );

  initial Clock = 1'b0;
  always #5 Clock = ~Clock;

  task automatic tick();
    @(posedge Clock);
    #1;
  endtask

  task automatic drive(input logic v, input int idx, input logic s, input logic f, input logic r);
    InValid  = v;
    InIndex  = W'(idx);
    InSet    = s;
    Flush    = f;
    OutReady = r;
  endtask

  task automatic drain();
    drive(0, 0, 0, 0, 1);
    tick();
    drive(0, 0, 0, 0, 0);
  endtask

  function automatic logic [N-1:0] modelMask();
    logic [N-1:0] m;
    for (int i = 0; i < N; i++) m[i] = modelBits[i];
    return m;
  endfunction

  function automatic int modelCount();
    int c;
    c = 0;
    for (int i = 0; i < N; i++) c += modelBits[i] ? 1 : 0;
    return c;
  endfunction

  task automatic test_reset();
    drive(0, 0, 0, 0, 0);
    ResetN = 1'b0;
    repeat (2) @(posedge Clock);
    #1;
    checks++;
    if ({OutValid, InReady, OutMask, OutCount} !== {1'b0, 1'b1, 8'h00, 4'd0}) begin
      errors++;
      $display("[TB] FAIL reset: valid=%b ready=%b mask=%h count=%0d, expected 0 1 00 0",
               OutValid, InReady, OutMask, OutCount);
    end
    ResetN = 1'b1;
  endtask

  task automatic test_basic();
    drive(1, 1, 1, 0, 0); tick();
    drive(1, 3, 1, 0, 0); tick();
    drive(1, 6, 1, 0, 0); tick();
    checks++;
    if (OutMask !== 8'h4A || OutValid !== 1'b0) begin
      errors++;
      $display("[TB] FAIL basic_collect: mask=%h valid=%b, expected 4a 0", OutMask, OutValid);
    end
    drive(0, 0, 0, 1, 0); tick();
    checks++;
    if ({OutValid, InReady, OutMask, OutCount} !== {1'b1, 1'b0, 8'h4A, 4'd3}) begin
      errors++;
      $display("[TB] FAIL basic_emit: valid=%b ready=%b mask=%h count=%0d, expected 1 0 4a 3",
               OutValid, InReady, OutMask, OutCount);
    end
    drain();
    checks++;
    if ({OutValid, InReady, OutMask} !== {1'b0, 1'b1, 8'h00}) begin
      errors++;
      $display("[TB] FAIL basic_drain: valid=%b ready=%b mask=%h, expected 0 1 00",
               OutValid, InReady, OutMask);
    end
  endtask

  task automatic test_idempotent();
    drive(1, 2, 1, 0, 0); tick();
    drive(1, 2, 0, 0, 0); tick();
    checks++;
    if (OutMask !== 8'h00) begin
      errors++;
      $display("[TB] FAIL clear_bit: mask=%h, expected 00", OutMask);
    end
    drive(1, 2, 1, 0, 0); tick();
    drive(1, 2, 1, 0, 0); tick();
    drive(0, 0, 0, 1, 0); tick();
    checks++;
    if ({OutValid, OutMask, OutCount} !== {1'b1, 8'h04, 4'd1}) begin
      errors++;
      $display("[TB] FAIL idempotent: valid=%b mask=%h count=%0d, expected 1 04 1",
               OutValid, OutMask, OutCount);
    end
    drain();
  endtask

  task automatic test_auto_emit();
    for (int i = 0; i < N - 1; i++) begin
      drive(1, i, 1, 0, 0); tick();
    end
    checks++;
    if (OutMask !== 8'h7F || OutValid !== 1'b0) begin
      errors++;
      $display("[TB] FAIL auto_pre: mask=%h valid=%b, expected 7f 0", OutMask, OutValid);
    end
    drive(1, N - 1, 1, 0, 0); tick();
    drive(0, 0, 0, 0, 0);
    for (int i = 0; i < 3; i++) begin
      checks++;
      if ({OutValid, InReady, OutMask, OutCount} !== {1'b1, 1'b0, 8'hFF, 4'd8}) begin
        errors++;
        $display("[TB] FAIL auto_emit: valid=%b ready=%b mask=%h count=%0d, expected 1 0 ff 8",
                 OutValid, InReady, OutMask, OutCount);
      end
      tick();
    end
    drain();
  endtask

  task automatic test_hold();
    drive(1, 4, 1, 1, 0); tick();
    drive(1, 0, 1, 1, 0);
    for (int i = 0; i < 5; i++) begin
      tick();
      checks++;
      if ({OutValid, InReady, OutMask} !== {1'b1, 1'b0, 8'h10}) begin
        errors++;
        $display("[TB] FAIL hold: valid=%b ready=%b mask=%h, expected 1 0 10",
                 OutValid, InReady, OutMask);
      end
    end
    drive(1, 0, 1, 1, 1); tick();
    drive(0, 0, 0, 0, 0);
    checks++;
    if ({OutValid, InReady, OutMask} !== {1'b0, 1'b1, 8'h00}) begin
      errors++;
      $display("[TB] FAIL hold_release: valid=%b ready=%b mask=%h, expected 0 1 00",
               OutValid, InReady, OutMask);
    end
  endtask

  task automatic test_flush_same_cycle();
    drive(1, 5, 1, 1, 0); tick();
    drive(0, 0, 0, 0, 0);
    checks++;
    if ({OutValid, OutMask, OutCount} !== {1'b1, 8'h20, 4'd1}) begin
      errors++;
      $display("[TB] FAIL flush_same_cycle: valid=%b mask=%h count=%0d, expected 1 20 1",
               OutValid, OutMask, OutCount);
    end
    drain();
    drive(0, 0, 0, 1, 0); tick();
    drive(0, 0, 0, 0, 0);
    checks++;
    if ({OutValid, OutMask, OutCount} !== {1'b1, 8'h00, 4'd0}) begin
      errors++;
      $display("[TB] FAIL empty_flush: valid=%b mask=%h count=%0d, expected 1 00 0",
               OutValid, OutMask, OutCount);
    end
    drain();
  endtask

  task automatic test_async_reset();
    for (int i = 0; i < 4; i++) begin
      drive(1, i, 1, 0, 0); tick();
    end
    drive(0, 0, 0, 1, 0); tick();
    drive(0, 0, 0, 0, 0);
    checks++;
    if ({OutValid, OutMask} !== {1'b1, 8'h0F}) begin
      errors++;
      $display("[TB] FAIL pre_reset_emit: valid=%b mask=%h, expected 1 0f", OutValid, OutMask);
    end
    #2;
    ResetN = 1'b0;
    #1;
    checks++;
    if ({OutValid, InReady, OutMask, OutCount} !== {1'b0, 1'b1, 8'h00, 4'd0}) begin
      errors++;
      $display("[TB] FAIL async_reset: valid=%b ready=%b mask=%h count=%0d, expected 0 1 00 0",
               OutValid, InReady, OutMask, OutCount);
    end
    ResetN = 1'b1;
    drive(1, 7, 1, 0, 0); tick();
    drive(0, 0, 0, 1, 0); tick();
    drive(0, 0, 0, 0, 0);
    checks++;
    if ({OutValid, OutMask, OutCount} !== {1'b1, 8'h80, 4'd1}) begin
      errors++;
      $display("[TB] FAIL after_reset: valid=%b mask=%h count=%0d, expected 1 80 1",
               OutValid, OutMask, OutCount);
    end
    drain();
  endtask

  task automatic test_random();
    logic v, s, f, r;
    int   idx;
    for (int i = 0; i < N; i++) modelBits[i] = 1'b0;
    modelEmit = 1'b0;
    for (int cyc = 0; cyc < 400; cyc++) begin
      v   = ($urandom_range(0, 3) != 0);
      idx = $urandom_range(0, N - 1);
      s   = ($urandom_range(0, 3) != 0);
      f   = ($urandom_range(0, 9) == 0);
      r   = ($urandom_range(0, 2) == 0);
      drive(v, idx, s, f, r);
      if (!modelEmit) begin
        if (v) modelBits[idx] = s;
        if (f || modelCount() == N) modelEmit = 1'b1;
      end else if (r) begin
        for (int i = 0; i < N; i++) modelBits[i] = 1'b0;
        modelEmit = 1'b0;
      end
      tick();
      checks++;
      if (OutMask !== modelMask() || OutCount !== (W+1)'(modelCount()) ||
          OutValid !== modelEmit || InReady !== !modelEmit) begin
        errors++;
        $display("[TB] FAIL random cycle %0d: mask=%h count=%0d valid=%b ready=%b, expected %h %0d %b %b",
                 cyc, OutMask, OutCount, OutValid, InReady,
                 modelMask(), modelCount(), modelEmit, !modelEmit);
      end
    end
    drain();
  endtask

  initial begin
    checks = 0;
    errors = 0;
    test_reset();
    test_basic();
    test_idempotent();
    test_auto_emit();
    test_hold();
    test_flush_same_cycle();
    test_async_reset();
    test_random();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
